// File: rtl/llc_pkg.sv
// Shared types and defaults for the low-level controller: FSM state encoding,
// width defaults and the event-queue counter width helper.
package llc_pkg;
    localparam int DATA_W_DEF = 64;
    localparam int TAG_W_DEF  = 8;

    // Encoding 3'd1 is reserved and never entered.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EVAL = 3'd2,
        ST_DONE = 3'd3
    } llc_state_e;

    // The occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/llc_scheduler_if.sv
// Event-in / evaluation-out bundle between the monitor input ports, the
// scheduler and the per-layer datapath.
interface llc_scheduler_if
    import llc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int NUM_LAYERS = 3
);
    logic signed [DATA_W-1:0] input_x;
    logic                     new_input;
    logic signed [DATA_W-1:0] eval_x;
    logic [TAG_W-1:0]         eval_tag;
    logic [NUM_LAYERS-1:0]    layer_en;
    logic                     eval_done;

    modport master (
        output input_x, new_input,
        input  eval_x, eval_tag, layer_en, eval_done
    );

    modport slave (
        input  input_x, new_input,
        output eval_x, eval_tag, layer_en, eval_done
    );
endinterface

// File: rtl/event_fifo.sv
// Circular event queue with full/empty status and a sticky drop flag; a push
// into a full queue is accepted only when a pop happens in the same cycle.
module event_fifo
    import llc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              push_valid,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign push_valid = push & (~full | pop);
    assign pop_valid  = pop & ~empty;
    assign dout       = mem_r[rd_ptr_r];
    assign overflow   = overflow_r;

    // Entry storage; slots are only read after being written, so no reset.
    always_ff @(posedge clk) begin
        if (en && push_valid) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy count and the sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (en) begin
            if (push_valid) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_valid) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_valid, pop_valid})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (push && !push_valid) begin
                overflow_r <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/llc_scheduler.sv
// Pops queued input events one at a time and walks the evaluation layers with a
// one-hot enable, pulsing eval_done after the last layer.
module llc_scheduler
    import llc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = 4,
    parameter int NUM_LAYERS = 3,
    parameter int TAG_W      = TAG_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    llc_scheduler_if.slave bus,
    output logic           busy,
    output logic           q_push,
    output logic           q_push_valid,
    output logic           q_pop,
    output logic           q_pop_valid,
    output logic           q_full,
    output logic           q_empty,
    output logic           q_overflow,
    output logic [2:0]     llc_state
);
    localparam int LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [LIDX_W-1:0]     LAST_IDX = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] LAYER0   = NUM_LAYERS'(1);

    llc_state_e            state_r;
    logic [LIDX_W-1:0]     layer_idx_r;
    logic [NUM_LAYERS-1:0] layer_en_r;
    logic                  eval_done_r;
    logic                  busy_r;
    logic [DATA_W-1:0]     eval_x_r;
    logic [TAG_W-1:0]      eval_tag_r;
    logic [TAG_W-1:0]      tag_cnt_r;

    logic                  q_push_s;
    logic                  q_pop_s;
    logic                  q_push_valid_s;
    logic                  q_pop_valid_s;
    logic                  q_full_s;
    logic                  q_empty_s;
    logic                  q_overflow_s;
    logic [DATA_W-1:0]     head_s;

    event_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .push       (q_push_s),
        .pop        (q_pop_s),
        .din        (bus.input_x),
        .dout       (head_s),
        .push_valid (q_push_valid_s),
        .pop_valid  (q_pop_valid_s),
        .full       (q_full_s),
        .empty      (q_empty_s),
        .overflow   (q_overflow_s)
    );

    // Queue requests; both are suppressed while the block is frozen.
    always_comb begin
        q_push_s = 1'b0;
        q_pop_s  = 1'b0;
        if (en) begin
            q_push_s = bus.new_input;
            q_pop_s  = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && !q_empty_s;
        end else begin
            q_push_s = 1'b0;
            q_pop_s  = 1'b0;
        end
    end

    // Sequencer: pop, step one layer per cycle, flag completion, repeat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            layer_idx_r <= {LIDX_W{1'b0}};
            layer_en_r  <= {NUM_LAYERS{1'b0}};
            eval_done_r <= 1'b0;
            busy_r      <= 1'b0;
            eval_x_r    <= {DATA_W{1'b0}};
            eval_tag_r  <= {TAG_W{1'b0}};
            tag_cnt_r   <= {TAG_W{1'b0}};
        end else if (en) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (q_pop_valid_s) begin
                        state_r     <= ST_EVAL;
                        eval_x_r    <= head_s;
                        eval_tag_r  <= tag_cnt_r;
                        tag_cnt_r   <= tag_cnt_r + TAG_W'(1);
                        layer_idx_r <= {LIDX_W{1'b0}};
                        layer_en_r  <= LAYER0;
                        eval_done_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        layer_en_r  <= {NUM_LAYERS{1'b0}};
                        eval_done_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    busy_r <= 1'b1;
                    if (layer_idx_r == LAST_IDX) begin
                        state_r     <= ST_DONE;
                        layer_en_r  <= {NUM_LAYERS{1'b0}};
                        eval_done_r <= 1'b1;
                    end else begin
                        layer_idx_r <= layer_idx_r + LIDX_W'(1);
                        layer_en_r  <= layer_en_r << 1'b1;
                        eval_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    layer_en_r  <= {NUM_LAYERS{1'b0}};
                    eval_done_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.eval_x    = eval_x_r;
    assign bus.eval_tag  = eval_tag_r;
    assign bus.layer_en  = layer_en_r;
    assign bus.eval_done = eval_done_r;
    assign busy          = busy_r;
    assign llc_state     = state_r;
    assign q_push        = q_push_s;
    assign q_push_valid  = q_push_valid_s;
    assign q_pop         = q_pop_s;
    assign q_pop_valid   = q_pop_valid_s;
    assign q_full        = q_full_s;
    assign q_empty       = q_empty_s;
    assign q_overflow    = q_overflow_s;
endmodule

// File: tb/tb_llc_scheduler.sv
// Directed, table-driven bench for llc_scheduler (DEPTH=4, NUM_LAYERS=3, TAG_W=8).
module tb_llc_scheduler;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [2:0] S_I = 3'd0;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_D = 3'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       busy, q_push, q_push_valid, q_pop, q_pop_valid;
    logic       q_full, q_empty, q_overflow;
    logic [2:0] llc_state;

    always #5 clk = ~clk;

    llc_scheduler_if #(.DATA_W(64), .TAG_W(8), .NUM_LAYERS(3)) bus ();

    llc_scheduler #(.DATA_W(64), .DEPTH(4), .NUM_LAYERS(3), .TAG_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .bus          (bus),
        .busy         (busy),
        .q_push       (q_push),
        .q_push_valid (q_push_valid),
        .q_pop        (q_pop),
        .q_pop_valid  (q_pop_valid),
        .q_full       (q_full),
        .q_empty      (q_empty),
        .q_overflow   (q_overflow),
        .llc_state    (llc_state)
    );

    // One clock cycle: inputs, expected pre-edge requests, expected post-edge state.
    typedef struct {
        logic        e;
        logic        nw;
        logic [63:0] x;
        logic        pp;
        logic        ppv;
        logic        pop;
        logic [2:0]  st;
        logic [2:0]  le;
        logic        dn;
        logic        bz;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic [63:0] ex;
        logic [7:0]  tg;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic void add(input logic e, input logic nw, input logic [63:0] x,
                                input logic pp, input logic ppv, input logic pop,
                                input logic [2:0] st, input logic [2:0] le,
                                input logic dn, input logic bz, input logic emp,
                                input logic ful, input logic ovf,
                                input logic [63:0] ex, input logic [7:0] tg);
        vec_t v;
        v.e = e; v.nw = nw; v.x = x; v.pp = pp; v.ppv = ppv; v.pop = pop;
        v.st = st; v.le = le; v.dn = dn; v.bz = bz; v.emp = emp; v.ful = ful;
        v.ovf = ovf; v.ex = ex; v.tg = tg;
        vq.push_back(v);
    endfunction

    task automatic run_table(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            en            = vq[i].e;
            bus.new_input = vq[i].nw;
            bus.input_x   = vq[i].x;
            #1;
            chk($sformatf("%s[%0d].q_push", name, i), q_push, vq[i].pp);
            chk($sformatf("%s[%0d].q_push_valid", name, i), q_push_valid, vq[i].ppv);
            chk($sformatf("%s[%0d].q_pop", name, i), q_pop, vq[i].pop);
            chk($sformatf("%s[%0d].q_pop_valid", name, i), q_pop_valid, vq[i].pop);
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].llc_state", name, i), llc_state, vq[i].st);
            chk($sformatf("%s[%0d].layer_en", name, i), bus.layer_en, vq[i].le);
            chk($sformatf("%s[%0d].eval_done", name, i), bus.eval_done, vq[i].dn);
            chk($sformatf("%s[%0d].busy", name, i), busy, vq[i].bz);
            chk($sformatf("%s[%0d].q_empty", name, i), q_empty, vq[i].emp);
            chk($sformatf("%s[%0d].q_full", name, i), q_full, vq[i].ful);
            chk($sformatf("%s[%0d].q_overflow", name, i), q_overflow, vq[i].ovf);
            chk($sformatf("%s[%0d].eval_x", name, i), bus.eval_x, vq[i].ex);
            chk($sformatf("%s[%0d].eval_tag", name, i), bus.eval_tag, vq[i].tg);
        end
        vq.delete();
    endtask

    // Asynchronous reset, checked immediately (before any clock edge).
    task automatic do_reset(input string name);
        en            = 1'b1;
        bus.new_input = 1'b0;
        bus.input_x   = 64'd0;
        rst           = 1'b0;
        #1;
        chk({name, ".llc_state"}, llc_state, 3'd0);
        chk({name, ".layer_en"}, bus.layer_en, 3'b000);
        chk({name, ".eval_done"}, bus.eval_done, 1'b0);
        chk({name, ".busy"}, busy, 1'b0);
        chk({name, ".q_empty"}, q_empty, 1'b1);
        chk({name, ".q_full"}, q_full, 1'b0);
        chk({name, ".q_overflow"}, q_overflow, 1'b0);
        chk({name, ".q_pop"}, q_pop, 1'b0);
        chk({name, ".eval_x"}, bus.eval_x, 64'd0);
        chk({name, ".eval_tag"}, bus.eval_tag, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [63:0] px;
        logic [7:0]  pt;
        rst           = 1'b1;
        en            = 1'b1;
        bus.new_input = 1'b0;
        bus.input_x   = 64'd0;
        #2;

        // Single event: pop, three layers, done, back to idle.
        do_reset("rst0");
        add(H, H, 64'd1, H, H, L, S_I, 3'b000, L, L, L, L, L, 64'd0, 8'd0);
        add(H, L, 64'd0, L, L, H, S_E, 3'b001, L, H, H, L, L, 64'd1, 8'd0);
        add(H, L, 64'd0, L, L, L, S_E, 3'b010, L, H, H, L, L, 64'd1, 8'd0);
        add(H, L, 64'd0, L, L, L, S_E, 3'b100, L, H, H, L, L, 64'd1, 8'd0);
        add(H, L, 64'd0, L, L, L, S_D, 3'b000, H, H, H, L, L, 64'd1, 8'd0);
        add(H, L, 64'd0, L, L, L, S_I, 3'b000, L, L, H, L, L, 64'd1, 8'd0);
        add(H, L, 64'd0, L, L, L, S_I, 3'b000, L, L, H, L, L, 64'd1, 8'd0);
        run_table("single");

        // Seven back-to-back events: x=6 rides the DONE-pop at full, x=7 drops.
        do_reset("rst1");
        add(H, H, 64'd1, H, H, L, S_I, 3'b000, L, L, L, L, L, 64'd0, 8'd0);
        add(H, H, 64'd2, H, H, H, S_E, 3'b001, L, H, L, L, L, 64'd1, 8'd0);
        add(H, H, 64'd3, H, H, L, S_E, 3'b010, L, H, L, L, L, 64'd1, 8'd0);
        add(H, H, 64'd4, H, H, L, S_E, 3'b100, L, H, L, L, L, 64'd1, 8'd0);
        add(H, H, 64'd5, H, H, L, S_D, 3'b000, H, H, L, H, L, 64'd1, 8'd0);
        add(H, H, 64'd6, H, H, H, S_E, 3'b001, L, H, L, H, L, 64'd2, 8'd1);
        add(H, H, 64'd7, H, L, L, S_E, 3'b010, L, H, L, H, H, 64'd2, 8'd1);
        add(H, L, 64'd0, L, L, L, S_E, 3'b100, L, H, L, H, H, 64'd2, 8'd1);
        add(H, L, 64'd0, L, L, L, S_D, 3'b000, H, H, L, H, H, 64'd2, 8'd1);
        for (int k = 3; k <= 6; k++) begin
            add(H, L, 64'd0, L, L, H, S_E, 3'b001, L, H, (k == 6), L, H, 64'(k), 8'(k - 1));
            add(H, L, 64'd0, L, L, L, S_E, 3'b010, L, H, (k == 6), L, H, 64'(k), 8'(k - 1));
            add(H, L, 64'd0, L, L, L, S_E, 3'b100, L, H, (k == 6), L, H, 64'(k), 8'(k - 1));
            add(H, L, 64'd0, L, L, L, S_D, 3'b000, H, H, (k == 6), L, H, 64'(k), 8'(k - 1));
        end
        add(H, L, 64'd0, L, L, L, S_I, 3'b000, L, L, H, L, H, 64'd6, 8'd5);
        run_table("burst7");

        // Freeze for three cycles on layer 1; pushes during the freeze are ignored.
        do_reset("rst2");
        add(H, H, 64'hFFFF_FFFF_FFFF_FFF7, H, H, L, S_I, 3'b000, L, L, L, L, L, 64'd0, 8'd0);
        add(H, L, 64'd0, L, L, H, S_E, 3'b001, L, H, H, L, L, 64'hFFFF_FFFF_FFFF_FFF7, 8'd0);
        add(H, L, 64'd0, L, L, L, S_E, 3'b010, L, H, H, L, L, 64'hFFFF_FFFF_FFFF_FFF7, 8'd0);
        add(L, H, 64'd10, L, L, L, S_E, 3'b010, L, H, H, L, L, 64'hFFFF_FFFF_FFFF_FFF7, 8'd0);
        add(L, H, 64'd11, L, L, L, S_E, 3'b010, L, H, H, L, L, 64'hFFFF_FFFF_FFFF_FFF7, 8'd0);
        add(L, L, 64'd0, L, L, L, S_E, 3'b010, L, H, H, L, L, 64'hFFFF_FFFF_FFFF_FFF7, 8'd0);
        add(H, L, 64'd0, L, L, L, S_E, 3'b100, L, H, H, L, L, 64'hFFFF_FFFF_FFFF_FFF7, 8'd0);
        add(H, L, 64'd0, L, L, L, S_D, 3'b000, H, H, H, L, L, 64'hFFFF_FFFF_FFFF_FFF7, 8'd0);
        add(H, L, 64'd0, L, L, L, S_I, 3'b000, L, L, H, L, L, 64'hFFFF_FFFF_FFFF_FFF7, 8'd0);
        run_table("freeze");

        // Reset during EVAL with two events queued, then a fresh event gets tag 0.
        do_reset("rst3");
        add(H, H, 64'd20, H, H, L, S_I, 3'b000, L, L, L, L, L, 64'd0, 8'd0);
        add(H, H, 64'd21, H, H, H, S_E, 3'b001, L, H, L, L, L, 64'd20, 8'd0);
        add(H, H, 64'd22, H, H, L, S_E, 3'b010, L, H, L, L, L, 64'd20, 8'd0);
        add(H, L, 64'd0, L, L, L, S_E, 3'b100, L, H, L, L, L, 64'd20, 8'd0);
        run_table("pre_abort");
        do_reset("abort");
        add(H, H, 64'd30, H, H, L, S_I, 3'b000, L, L, L, L, L, 64'd0, 8'd0);
        add(H, L, 64'd0, L, L, H, S_E, 3'b001, L, H, H, L, L, 64'd30, 8'd0);
        run_table("post_abort");

        // 257 single events: tag wraps 255 -> 0 with no drops.
        do_reset("rst4");
        px = 64'd0;
        pt = 8'd0;
        for (int i = 0; i < 257; i++) begin
            add(H, H, 64'(i + 1), H, H, L, S_I, 3'b000, L, L, L, L, L, px, pt);
            add(H, L, 64'd0, L, L, H, S_E, 3'b001, L, H, H, L, L, 64'(i + 1), 8'(i));
            add(H, L, 64'd0, L, L, L, S_E, 3'b010, L, H, H, L, L, 64'(i + 1), 8'(i));
            add(H, L, 64'd0, L, L, L, S_E, 3'b100, L, H, H, L, L, 64'(i + 1), 8'(i));
            add(H, L, 64'd0, L, L, L, S_D, 3'b000, H, H, H, L, L, 64'(i + 1), 8'(i));
            px = 64'(i + 1);
            pt = 8'(i);
        end
        add(H, L, 64'd0, L, L, L, S_I, 3'b000, L, L, H, L, L, 64'd257, 8'd0);
        run_table("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
